// File: rtl/mc_col_ctrl_if.sv
// Request/response bundle between a requester and the mc column controller.
// The bitlines and access switch stay outside the bundle as plain ports.
interface mc_col_ctrl_if;
  logic req;
  logic we;
  logic din;
  logic ready;
  logic dout;
  logic rvalid;
  logic err;
  logic wdone;

  modport master (
    output req, we, din,
    input  ready, dout, rvalid, err, wdone
  );

  modport slave (
    input  req, we, din,
    output ready, dout, rvalid, err, wdone
  );
endinterface

// File: rtl/mc_col_ctrl.sv
// Single-column read/write controller for the mc memory cell: sequences
// precharge, access/sense and write-drive phases on one bitline pair.
module mc_col_ctrl #(
  parameter int PRE_CYC   = 2,
  parameter int SENSE_CYC = 2,
  parameter int WR_CYC    = 2,
  parameter int CNT_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  mc_col_ctrl_if.slave bus,
  output logic         wl,
  inout  wire          bl,
  inout  wire          blb
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    ACC  = 3'd2,
    RREC = 3'd3,
    WDRV = 3'd4,
    WREC = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PRE_LD   = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] SENSE_LD = CNT_W'(SENSE_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             dout_q;
  logic             rvalid_q;
  logic             err_q;
  logic             wdone_q;
  logic             wl_q;
  logic             drv_q;
  logic             bl_q;
  logic             blb_q;

  // Returns {dout, err}; anything but a clean complementary pair
  // (equal, x or z) is reported as an error with dout forced to 0.
  function automatic logic [1:0] sense_decode(input logic b, input logic bb);
    case ({b, bb})
      2'b10:   sense_decode = 2'b10;
      2'b01:   sense_decode = 2'b00;
      default: sense_decode = 2'b01;
    endcase
  endfunction

  // Phase sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      ready_q  <= 1'b1;
      dout_q   <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      wdone_q  <= 1'b0;
      wl_q     <= 1'b0;
      drv_q    <= 1'b0;
      bl_q     <= 1'b0;
      blb_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            ready_q <= 1'b0;
            drv_q   <= 1'b1;
            if (bus.we) begin
              state_q <= WDRV;
              cnt_q   <= WR_LD;
              wl_q    <= 1'b1;
              bl_q    <= bus.din;
              blb_q   <= ~bus.din;
            end else begin
              state_q <= PRE;
              cnt_q   <= PRE_LD;
              wl_q    <= 1'b0;
              bl_q    <= 1'b1;
              blb_q   <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
            drv_q   <= 1'b0;
            wl_q    <= 1'b0;
          end
        end
        PRE: begin
          if (cnt_q == CNT_ZERO) begin
            // Release the precharged lines as the switch opens so only the cell drives them.
            state_q <= ACC;
            cnt_q   <= SENSE_LD;
            drv_q   <= 1'b0;
            wl_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ACC: begin
          if (cnt_q == CNT_ZERO) begin
            {dout_q, err_q} <= sense_decode(bl, blb);
            rvalid_q        <= 1'b1;
            wl_q            <= 1'b0;
            state_q         <= RREC;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        RREC: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        WDRV: begin
          if (cnt_q == CNT_ZERO) begin
            // Close the switch but keep the data on the lines for one more cycle.
            state_q <= WREC;
            wl_q    <= 1'b0;
            wdone_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        WREC: begin
          state_q <= IDLE;
          drv_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= CNT_ZERO;
          ready_q <= 1'b1;
          wl_q    <= 1'b0;
          drv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.dout   = dout_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.wdone  = wdone_q;
  assign wl         = wl_q;
  assign bl         = drv_q ? bl_q  : 1'bz;
  assign blb        = drv_q ? blb_q : 1'bz;

endmodule

// File: tb/tb_mc_col_ctrl.sv
// Bench for mc_col_ctrl: a behavioural cell on the bitlines, a value/written
// reference model, and per-scenario tasks with per-edge timing expectations.
module tb_mc_col_ctrl;
  localparam int PRE   = 2;
  localparam int SENSE = 2;
  localparam int WR    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wl;
  wire  bl;
  wire  blb;

  mc_col_ctrl_if bus ();

  mc_col_ctrl #(
    .PRE_CYC(PRE), .SENSE_CYC(SENSE), .WR_CYC(WR), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .wl(wl), .bl(bl), .blb(blb)
  );

  always #10 clk = ~clk;

  // Keepers: a released line reads as 1, so released reads 1/1.
  pullup pu_bl (bl);
  pullup pu_blb (blb);

  // Behavioural cell: drives its value while the switch is closed on a read,
  // and commits a write only if the lines still carry complementary data
  // just after the switch opens.
  logic c_val     = 1'b0;
  logic c_written = 1'b0;
  logic cell_rd   = 1'b0;

  assign bl  = (wl && cell_rd && c_written) ? c_val  : 1'bz;
  assign blb = (wl && cell_rd && c_written) ? ~c_val : 1'bz;

  always @(negedge wl) begin
    #1;
    if (!cell_rd && (bl !== blb) && !$isunknown({bl, blb})) begin
      c_val     = bl;
      c_written = 1'b1;
    end
  end

  // Reference model
  bit ref_val     = 1'b0;
  bit ref_written = 1'b0;
  bit last_dout   = 1'b0;
  bit last_err    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic issue(input bit we_i, input bit din_i);
    @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_req: got %b expected 1", bus.ready);
    end
    bus.req = 1'b1;
    bus.we  = we_i;
    bus.din = din_i;
    cell_rd = !we_i;
  endtask

  // Follows one accepted access from its accept edge (e=0) until idle again.
  task automatic track(input bit we_i, input bit din_i, input bit hold);
    int done;
    logic [3:0] exp_v;
    logic [3:0] got_v;
    logic [1:0] exp_rd;
    done    = we_i ? WR : (PRE + SENSE);
    cell_rd = !we_i;
    for (int e = 0; e <= done + 1; e++) begin
      @(posedge clk);
      #1;
      exp_v[3] = (e > done);
      exp_v[2] = we_i ? (e < WR) : (e >= PRE && e < PRE + SENSE);
      exp_v[1] = !we_i && (e == done);
      exp_v[0] = we_i && (e == done);
      got_v = {bus.ready, wl, bus.rvalid, bus.wdone};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL timing we=%0b edge=%0d {ready,wl,rvalid,wdone}: got %b expected %b",
                 we_i, e, got_v, exp_v);
      end
      if (we_i && e <= done) begin
        n_checks++;
        if ({bl, blb} !== {din_i, !din_i}) begin
          n_fail++;
          $display("FAIL write_drive edge=%0d {bl,blb}: got %b expected %b",
                   e, {bl, blb}, {din_i, !din_i});
        end
      end
      if (we_i && e == done + 1) begin
        n_checks++;
        if ({bl, blb, bus.dout, bus.err} !== {2'b11, last_dout, last_err}) begin
          n_fail++;
          $display("FAIL write_release {bl,blb,dout,err}: got %b expected %b",
                   {bl, blb, bus.dout, bus.err}, {2'b11, last_dout, last_err});
        end
      end
      if (!we_i && e == done) begin
        exp_rd = ref_written ? {ref_val, 1'b0} : 2'b01;
        n_checks++;
        if ({bus.dout, bus.err} !== exp_rd) begin
          n_fail++;
          $display("FAIL read_data {dout,err}: got %b expected %b",
                   {bus.dout, bus.err}, exp_rd);
        end
        {last_dout, last_err} = exp_rd;
      end
      if (e == 0 && !hold) begin
        @(negedge clk);
        bus.req = 1'b0;
      end
    end
    if (we_i) begin
      ref_val     = din_i;
      ref_written = 1'b1;
    end
    if (!hold) cell_rd = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    logic [7:0] got_v;
    got_v = {bus.ready, wl, bus.rvalid, bus.wdone, bus.err, bus.dout, bl, blb};
    n_checks++;
    if (got_v !== 8'b1000_0011) begin
      n_fail++;
      $display("FAIL %s {ready,wl,rvalid,wdone,err,dout,bl,blb}: got %b expected 10000011",
               tag, got_v);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_initial");
    @(negedge clk);
    rst = 1'b0;
    // Abort a read in the middle of its precharge phase.
    issue(1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_idle("reset_mid_read_immediate");
    bus.req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_idle("reset_held");
    end
    @(negedge clk);
    rst     = 1'b0;
    cell_rd = 1'b0;
  endtask

  task automatic test_unwritten_read();
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_read();
    issue(1'b1, 1'b0);
    track(1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b0);
    issue(1'b1, 1'b1);
    track(1'b1, 1'b1, 1'b0);
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // req stays high: one full access, then a second only once ready returns.
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b1);
    track(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    issue(1'b1, 1'b0);
    track(1'b1, 1'b0, 1'b0);
    issue(1'b1, 1'b1);
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    n_checks++;
    if (wl !== 1'b1) begin
      n_fail++;
      $display("FAIL wdrv_wl: got %b expected 1", wl);
    end
    #5;
    rst = 1'b1;
    #1;
    check_idle("reset_mid_write_immediate");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 1'b0);
    track(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit w;
    bit d;
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(w, d);
      track(w, d, 1'b0);
    end
  endtask

  initial begin
    bus.req = 1'b0;
    bus.we  = 1'b0;
    bus.din = 1'b0;
    test_reset();
    test_unwritten_read();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
